// File: rtl/ir_rx_ctrl.sv
// ir_rx_ctrl: sequences the IR decoder handshake, validates Samsung-32 frames,
// tags key-hold repeats and queues {address, command, repeat} entries in a
// first-word fall-through FIFO for the application logic.
module ir_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2750000,
  parameter bit CHECK_ADDR  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  output logic                          dec_enable,
  output logic                          dec_ack,
  input  logic                          dec_ready,
  input  logic [31:0]                   dec_command,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_addr,
  output logic [7:0]                    out_cmd,
  output logic                          out_repeat,
  output logic                          err_pulse,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CHECK, PUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   frameWord_q;
  logic [15:0]   lastCode_q;
  logic          lastValid_q;
  logic [HW-1:0] holdTimer_q;
  logic [16:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] count_q;
  logic          overflow_q;

  logic [7:0]    addr0, addr1, cmdByte, ncmdByte;
  logic          frameOk, isRepeat, pushEn, popEn, fifoFull, writeEn;
  logic [16:0]   headWord;

  assign addr0    = frameWord_q[7:0];
  assign addr1    = frameWord_q[15:8];
  assign cmdByte  = frameWord_q[23:16];
  assign ncmdByte = frameWord_q[31:24];
  assign frameOk  = (ncmdByte == ~cmdByte) && (!CHECK_ADDR || (addr0 == addr1));
  assign isRepeat = lastValid_q && ({addr0, cmdByte} == lastCode_q) && (holdTimer_q < HOLD_MAX);

  assign fifoFull = (count_q == LEVEL_MAX);
  assign popEn    = out_valid && out_ready;
  assign writeEn  = pushEn && (!fifoFull || popEn);
  assign headWord = fifoMem_q[rdPtr_q];

  assign out_valid  = (count_q != '0);
  assign out_addr   = out_valid ? headWord[16:9] : 8'h00;
  assign out_cmd    = out_valid ? headWord[8:1]  : 8'h00;
  assign out_repeat = out_valid ? headWord[0]    : 1'b0;
  assign overflow   = overflow_q;
  assign fifo_level = count_q;

  // Handshake FSM: next state plus the decoder/strobe outputs decoded from state.
  always_comb begin
    state_d    = state_q;
    dec_enable = 1'b0;
    dec_ack    = 1'b0;
    err_pulse  = 1'b0;
    pushEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = ARMED;
      end
      ARMED: begin
        dec_enable = 1'b1;
        if (dec_ready)  state_d = CAPTURE;
        else if (!run)  state_d = IDLE;
      end
      CAPTURE: begin
        dec_enable = 1'b1;
        dec_ack    = 1'b1;
        state_d    = CHECK;
      end
      CHECK: begin
        dec_enable = 1'b1;
        if (frameOk) begin
          state_d = PUSH;
        end else begin
          err_pulse = 1'b1;
          state_d   = run ? ARMED : IDLE;
        end
      end
      PUSH: begin
        dec_enable = 1'b1;
        pushEn     = 1'b1;
        state_d    = run ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, frame latch, last-code tracking and the saturating hold timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frameWord_q <= '0;
      lastCode_q  <= '0;
      lastValid_q <= 1'b0;
      holdTimer_q <= HOLD_MAX;
    end else begin
      state_q <= state_d;
      if (state_q == ARMED && dec_ready) frameWord_q <= dec_command;
      if (pushEn) begin
        lastCode_q  <= {addr0, cmdByte};
        lastValid_q <= 1'b1;
        holdTimer_q <= '0;
      end else if (holdTimer_q < HOLD_MAX) begin
        holdTimer_q <= holdTimer_q + 1'b1;
      end
    end
  end

  // FIFO storage; head is read combinationally and gated by out_valid.
  always_ff @(posedge clk) begin
    if (writeEn) fifoMem_q[wrPtr_q] <= {addr0, cmdByte, isRepeat};
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (writeEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (popEn)   rdPtr_q <= rdPtr_q + 1'b1;
      case ({writeEn, popEn})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pushEn && fifoFull && !popEn) overflow_q <= 1'b1;
      else if (clear_ovf)               overflow_q <= 1'b0;
    end
  end

endmodule
